// File: rtl/cube_root.sv
// ---------------------------------------------------------------------------
// cube_root -- sequential integer cube root, one result bit per clock.
//
// Computes root = floor(cbrt(x)) and rem = x - root^3 for a 32-bit unsigned
// radicand. The root is resolved MSB first. After the accept edge there are
// 11 CALC edges (bit 10 down to bit 0), so out_valid is high after the 11th
// edge following the accept. One result every 13 cycles at best:
// accept + 11 CALC + 1 output handshake.
//
// Optional feature macro: CUBE_ROOT_REM_EN
//   defined   : rem = x - root^3 is computed and registered.
//   undefined : rem is tied to 0. No remainder subtractor and no remainder
//               register are built.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operand x is valid
//   in_ready   out  1  block accepts an operand (IDLE only)
//   x          in  32  unsigned radicand
//   out_valid  out  1  root/rem valid (DONE only)
//   out_ready  in   1  consumer accepts the result
//   root       out 11  floor(cbrt(x))
//   rem        out 32  x - root^3 (0 when CUBE_ROOT_REM_EN is undefined)
// ---------------------------------------------------------------------------
module cube_root (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] root,
  output logic [31:0] rem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_x;      // latched radicand
  logic [10:0] r_r;      // partial root
  logic [3:0]  r_i;      // bit index being resolved
  logic [10:0] r_root;

  logic [10:0] w_trial;
  logic [33:0] w_trial_wide;
  logic [33:0] w_trial_cube;
  logic        w_take;
  logic [10:0] w_r_next;

  // Candidate root with the current bit set. The cube is formed at 34 bits
  // because 2047^3 does not fit in 32 bits. The radicand is zero-extended,
  // so the comparison is unsigned.
  assign w_trial      = r_r | (11'd1 << r_i);
  assign w_trial_wide = {23'd0, w_trial};
  assign w_trial_cube = w_trial_wide * w_trial_wide * w_trial_wide;
  assign w_take       = (w_trial_cube <= {2'b00, r_x});
  assign w_r_next     = w_take ? w_trial : r_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (r_i == 4'd0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Root datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= 32'd0;
      r_r    <= 11'd0;
      r_i    <= 4'd0;
      r_root <= 11'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x <= x;
            r_r <= 11'd0;
            r_i <= 4'd10;
          end
        end
        CALC: begin
          r_r <= w_r_next;
          if (r_i != 4'd0) begin
            r_i <= r_i - 4'd1;
          end else begin
            // The last bit decision is folded straight into the output.
            r_root <= w_r_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign root = r_root;

`ifdef CUBE_ROOT_REM_EN
  logic [31:0] r_rem;
  logic [31:0] w_r_wide;
  logic [31:0] w_rem;

  // The final root satisfies root^3 <= x < 2^32, so 32-bit arithmetic is
  // exact here.
  assign w_r_wide = {21'd0, w_r_next};
  assign w_rem    = r_x - (w_r_wide * w_r_wide * w_r_wide);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= 32'd0;
    end else if (r_state == CALC && r_i == 4'd0) begin
      r_rem <= w_rem;
    end
  end

  assign rem = r_rem;
`else
  assign rem = 32'd0;
`endif

endmodule

// File: tb/tb_cube_root.sv
// ---------------------------------------------------------------------------
// tb_cube_root -- self-checking bench for cube_root.
// Expected values come from a brute-force integer cube-root model. Expected
// rem follows the CUBE_ROOT_REM_EN build setting.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cube_root;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] root;
  logic [31:0] rem;

  int tests = 0;
  int fails = 0;

  cube_root dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  // Reference model: largest c with c^3 <= x, found by counting up.
  function automatic void model(input logic [31:0] xv,
                                output logic [10:0] er,
                                output logic [31:0] erem);
    longint unsigned c;
    longint unsigned xw;
    xw = {32'd0, xv};
    c  = 0;
    while ((c + 1) * (c + 1) * (c + 1) <= xw) c++;
    er = c[10:0];
`ifdef CUBE_ROOT_REM_EN
    erem = xv - c[31:0] * c[31:0] * c[31:0];
`else
    erem = 32'd0;
`endif
  endfunction

  // Present one operand and return just after its accept edge.
  task automatic accept(input logic [31:0] xv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    x        = xv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = $urandom;  // must be ignored from here on
  endtask

  // Count edges until out_valid is seen at a negedge. out_ready toggles
  // randomly meanwhile because it must be ignored outside DONE.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) out_ready = 1'($urandom);
    end while (!out_valid && lat < 30);
  endtask

  // Complete the output handshake. Returns at a negedge with the DUT in IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 32'd0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests++; if (root !== 11'd0) begin fails++; $display("FAIL reset_root got=%0d exp=0", root); end
    tests++; if (rem !== 32'd0) begin fails++; $display("FAIL reset_rem got=%0d exp=0", rem); end
    // The operand is presented together with reset release and must be
    // taken on the very next edge.
    rst = 1'b0; in_valid = 1'b1; x = 32'd8;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    wait_result(lat);
    tests++; if (lat !== 11) begin fails++; $display("FAIL first_accept_latency got=%0d exp=11", lat); end
    tests++; if (root !== 11'd2) begin fails++; $display("FAIL first_accept_root got=%0d exp=2", root); end
    $display("[TB] reset: x=8 root=%0d rem=%0d lat=%0d", root, rem, lat);
    release_result();
  endtask

  task automatic test_vectors();
    logic [31:0] vec [8] = '{32'd0, 32'd27, 32'd26, 32'd1000000, 32'hFFFF_FFFF,
                             32'd1, 32'd7, 32'd4291015625};
    logic [10:0] er;
    logic [31:0] erem;
    int lat;
    for (int k = 0; k < 8; k++) begin
      model(vec[k], er, erem);
      accept(vec[k]);
      wait_result(lat);
      tests++; if (lat !== 11) begin fails++; $display("FAIL vec_latency x=%0d got=%0d exp=11", vec[k], lat); end
      tests++; if (root !== er) begin fails++; $display("FAIL vec_root x=%0d got=%0d exp=%0d", vec[k], root, er); end
      tests++; if (rem !== erem) begin fails++; $display("FAIL vec_rem x=%0d got=%0d exp=%0d", vec[k], rem, erem); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL vec_in_ready_in_done got=%0b exp=0", in_ready); end
      $display("[TB] vector: x=%0d root=%0d rem=%0d lat=%0d", vec[k], root, rem, lat);
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] er;
    logic [31:0] erem;
    int lat;
    model(32'd64, er, erem);
    accept(32'd64);
    wait_result(lat);
    tests++; if (lat !== 11) begin fails++; $display("FAIL bp_latency got=%0d exp=11", lat); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid cyc=%0d got=%0b exp=1", c, out_valid); end
      tests++; if (root !== er) begin fails++; $display("FAIL bp_root cyc=%0d got=%0d exp=%0d", c, root, er); end
      tests++; if (rem !== erem) begin fails++; $display("FAIL bp_rem cyc=%0d got=%0d exp=%0d", c, rem, erem); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
    end
    // Next operand is offered along with out_ready; it may only be taken on
    // the edge after the handshake edge.
    out_ready = 1'b1; in_valid = 1'b1; x = 32'd125;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_after got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_out_valid_after got=%0b exp=0", out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    wait_result(lat);
    tests++; if (lat !== 11) begin fails++; $display("FAIL bp_next_latency got=%0d exp=11", lat); end
    tests++; if (root !== 11'd5) begin fails++; $display("FAIL bp_next_root got=%0d exp=5", root); end
    $display("[TB] backpressure: x=64 held 5 cycles, next x=125 root=%0d lat=%0d", root, lat);
    release_result();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit seen;
    accept(32'd27);
    wait_result(lat);
    release_result();
    accept(32'd1000);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    tests++; if (root !== 11'd0) begin fails++; $display("FAIL midrst_root got=%0d exp=0", root); end
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_result got=%0b exp=0", seen); end
    accept(32'd8);
    wait_result(lat);
    tests++; if (root !== 11'd2) begin fails++; $display("FAIL midrst_next_root got=%0d exp=2", root); end
    tests++; if (lat !== 11) begin fails++; $display("FAIL midrst_next_latency got=%0d exp=11", lat); end
    $display("[TB] reset mid-calc: aborted x=1000, then x=8 root=%0d lat=%0d", root, lat);
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [4];
    logic [10:0] er;
    logic [31:0] erem;
    int cyc, prev, k;
    for (int j = 0; j < 4; j++) ops[j] = $urandom;
    in_valid = 1'b1; out_ready = 1'b1; x = ops[0];
    cyc = 0; prev = -1; k = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) begin
        model(ops[k], er, erem);
        tests++; if (root !== er) begin fails++; $display("FAIL b2b_root x=%0d got=%0d exp=%0d", ops[k], root, er); end
        tests++; if (rem !== erem) begin fails++; $display("FAIL b2b_rem x=%0d got=%0d exp=%0d", ops[k], rem, erem); end
        if (prev >= 0) begin
          tests++; if (cyc - prev !== 13) begin fails++; $display("FAIL b2b_interval got=%0d exp=13", cyc - prev); end
        end
        $display("[TB] back-to-back: x=%0d root=%0d rem=%0d cycle=%0d", ops[k], root, rem, cyc);
        prev = cyc;
        k++;
        if (k < 4) x = ops[k];
        else in_valid = 1'b0;
      end
    end
    tests++; if (k !== 4) begin fails++; $display("FAIL b2b_count got=%0d exp=4", k); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] xv;
    logic [10:0] er;
    logic [31:0] erem;
    int lat, stall;
    for (int k = 0; k < 25; k++) begin
      xv    = $urandom >> $urandom_range(0, 31);
      stall = $urandom_range(0, 3);
      model(xv, er, erem);
      accept(xv);
      wait_result(lat);
      out_ready = 1'b0;
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
      end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rand_out_valid x=%0d got=%0b exp=1", xv, out_valid); end
      tests++; if (lat !== 11) begin fails++; $display("FAIL rand_latency x=%0d got=%0d exp=11", xv, lat); end
      tests++; if (root !== er) begin fails++; $display("FAIL rand_root x=%0d got=%0d exp=%0d", xv, root, er); end
      tests++; if (rem !== erem) begin fails++; $display("FAIL rand_rem x=%0d got=%0d exp=%0d", xv, rem, erem); end
      $display("[TB] random: x=%0d root=%0d rem=%0d stall=%0d", xv, root, rem, stall);
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
